// File: rtl/ro_pkg.sv
// Shared types and default widths for the ring-oscillator sampling controller.
package ro_pkg;

    localparam int unsigned DEF_SIZE_WIDTH   = 32;
    localparam int unsigned DEF_COUNT_WIDTH  = 32;
    localparam int unsigned DEF_LINE_WIDTH   = 512;
    localparam int unsigned SAMPLES_PER_LINE = DEF_LINE_WIDTH / DEF_COUNT_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } ro_state_t;

endpackage

// File: rtl/ro_sample_ctrl_if.sv
// Control, ring-oscillator and DMA-write signals of the sampling controller.
interface ro_sample_ctrl_if #(
    parameter int unsigned SIZE_WIDTH = ro_pkg::DEF_SIZE_WIDTH,
    parameter int unsigned LINE_WIDTH = ro_pkg::DEF_LINE_WIDTH
);

    logic                  go;
    logic [SIZE_WIDTH-1:0] num_samples;
    logic [SIZE_WIDTH-1:0] collect_cycles;
    logic                  done;
    logic                  ro_en;
    logic                  ro_edge;
    logic                  wr_valid;
    logic [LINE_WIDTH-1:0] wr_data;
    logic                  wr_full;

    // Host / environment side: memory map, oscillator and DMA FIFO.
    modport master (
        output go, num_samples, collect_cycles, ro_edge, wr_full,
        input  done, ro_en, wr_valid, wr_data
    );

    // Controller side.
    modport slave (
        input  go, num_samples, collect_cycles, ro_edge, wr_full,
        output done, ro_en, wr_valid, wr_data
    );

endinterface

// File: rtl/ro_window_counter.sv
// Window-length counter plus saturating edge counter; `last` flags the final
// cycle of a window and `count` already includes that cycle's edge.
module ro_window_counter
    import ro_pkg::*;
#(
    parameter int unsigned SIZE_WIDTH  = DEF_SIZE_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   en,
    input  logic [SIZE_WIDTH-1:0]  len,
    input  logic                   ro_edge,
    output logic                   last,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [SIZE_WIDTH-1:0]  win_q, win_d;
    logic [COUNT_WIDTH-1:0] edge_q, edge_d;

    // len is never 0 here; the controller clamps it to at least 1.
    always_comb begin
        last   = en && (win_q == len - SIZE_WIDTH'(1));
        count  = edge_q;
        win_d  = win_q;
        edge_d = edge_q;
        if (en && ro_edge && (edge_q != '1)) begin
            count = edge_q + COUNT_WIDTH'(1);
        end
        if (start) begin
            win_d  = '0;
            edge_d = '0;
        end else if (en) begin
            if (last) begin
                win_d  = '0;
                edge_d = '0;
            end else begin
                win_d  = win_q + SIZE_WIDTH'(1);
                edge_d = count;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q  <= '0;
            edge_q <= '0;
        end else begin
            win_q  <= win_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator sampling controller: collects 16 window counts per cache
// line and pushes each line into the DMA write FIFO until the run completes.
module ro_sample_ctrl
    import ro_pkg::*;
#(
    parameter int unsigned SIZE_WIDTH  = DEF_SIZE_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int unsigned LINE_WIDTH  = DEF_LINE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    ro_sample_ctrl_if.slave  bus
);

    localparam int unsigned LANES = LINE_WIDTH / COUNT_WIDTH;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    ro_state_t              state_q;
    logic [SIZE_WIDTH-1:0]  num_q;
    logic [SIZE_WIDTH-1:0]  len_q;
    logic [SIZE_WIDTH-1:0]  lines_q;
    logic [IDX_W-1:0]       idx_q;
    logic [LINE_WIDTH-1:0]  data_q;
    logic                   done_q;
    logic                   ro_en_q;

    logic                   start_run;
    logic                   win_last;
    logic [COUNT_WIDTH-1:0] win_count;
    logic [SIZE_WIDTH-1:0]  lines_inc;

    assign start_run = bus.go && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign lines_inc = lines_q + SIZE_WIDTH'(1);

    ro_window_counter #(
        .SIZE_WIDTH  (SIZE_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .start   (start_run),
        .en      (state_q == ST_COLLECT),
        .len     (len_q),
        .ro_edge (ro_edge_gated()),
        .last    (win_last),
        .count   (win_count)
    );

    function automatic logic ro_edge_gated();
        return bus.ro_edge;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            num_q   <= '0;
            len_q   <= '0;
            lines_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ro_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.go) begin
                        num_q   <= bus.num_samples;
                        len_q   <= (bus.collect_cycles == '0) ? SIZE_WIDTH'(1) : bus.collect_cycles;
                        idx_q   <= '0;
                        lines_q <= '0;
                        if (bus.num_samples == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            ro_en_q <= 1'b0;
                        end else begin
                            state_q <= ST_COLLECT;
                            done_q  <= 1'b0;
                            ro_en_q <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (win_last) begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            if (idx_q == IDX_W'(l)) begin
                                data_q[l*COUNT_WIDTH +: COUNT_WIDTH] <= win_count;
                            end
                        end
                        if (idx_q == IDX_W'(LANES - 1)) begin
                            state_q <= ST_WRITE;
                            ro_en_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (!bus.wr_full) begin
                        lines_q <= lines_inc;
                        if (lines_inc == num_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                            idx_q   <= '0;
                            ro_en_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The strobe must be qualified by the FIFO's current full flag, so it is
    // decoded from the registered state rather than registered itself.
    assign bus.wr_valid = (state_q == ST_WRITE) && !bus.wr_full;
    assign bus.wr_data  = data_q;
    assign bus.done     = done_q;
    assign bus.ro_en    = ro_en_q;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Directed bench for ro_sample_ctrl: cycle-indexed stimulus after each go,
// with hand-computed write cycles, lane counts and done timing.
module tb_ro_sample_ctrl;
    import ro_pkg::*;

    localparam int unsigned LW   = 512;
    localparam int unsigned CW   = 32;
    localparam int          MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ro_sample_ctrl_if bus ();

    ro_sample_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit              en_hist   [MAXC];
    bit              val_hist  [MAXC];
    bit              done_hist [MAXC];
    logic [LW-1:0]   data_hist [MAXC];
    int              wr_cyc [$];
    logic [LW-1:0]   wr_dat [$];
    int              done_cyc;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack2(input int unsigned a, input int unsigned b);
        logic [LW-1:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            d[i*CW +: CW] = ((i % 2) == 0) ? CW'(a) : CW'(b);
        end
        return d;
    endfunction

    function automatic int wr_at(input int n);
        return (wr_cyc.size() > n) ? wr_cyc[n] : -1;
    endfunction

    function automatic logic [LW-1:0] dat_at(input int n);
        return (wr_dat.size() > n) ? wr_dat[n] : '1;
    endfunction

    // edge_mode: 0 low, 1 held high, 2 high on odd cycles.
    task automatic run(input int ns, input int cc, input int alt_cyc, input int alt_ns,
                       input int go_a, input int go_b, input int edge_mode,
                       input int full_from, input int full_len, input int rst_cyc,
                       input int budget);
        wr_cyc.delete();
        wr_dat.delete();
        done_cyc = -1;
        for (int i = 0; i < MAXC; i++) begin
            en_hist[i]   = 1'b0;
            val_hist[i]  = 1'b0;
            done_hist[i] = 1'b0;
            data_hist[i] = '0;
        end
        @(negedge clk);
        bus.go             = 1'b1;
        bus.num_samples    = 32'(ns);
        bus.collect_cycles = 32'(cc);
        bus.ro_edge        = 1'b0;
        bus.wr_full        = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            bus.go = (k == go_a) || (k == go_b);
            if (alt_cyc > 0 && k >= alt_cyc) begin
                bus.num_samples    = 32'(alt_ns);
                bus.collect_cycles = 32'd7;
            end
            bus.ro_edge = (edge_mode == 1) || ((edge_mode == 2) && ((k % 2) == 1));
            bus.wr_full = (k >= full_from) && (k < full_from + full_len);
            if (k == rst_cyc) rst = 1'b0;
            #1;
            en_hist[k]   = bus.ro_en;
            val_hist[k]  = bus.wr_valid;
            done_hist[k] = bus.done;
            data_hist[k] = bus.wr_data;
            if (bus.done && done_cyc < 0) done_cyc = k;
            if (bus.wr_valid) begin
                wr_cyc.push_back(k);
                wr_dat.push_back(bus.wr_data);
            end
            if (k == rst_cyc) break;
        end
        bus.go      = 1'b0;
        bus.ro_edge = 1'b0;
        bus.wr_full = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.go             = 1'b0;
        bus.num_samples    = '0;
        bus.collect_cycles = '0;
        bus.ro_edge        = 1'b0;
        bus.wr_full        = 1'b0;
        rst                = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_done",     LW'(bus.done),     LW'(0));
        check_eq("rst_ro_en",    LW'(bus.ro_en),    LW'(0));
        check_eq("rst_wr_valid", LW'(bus.wr_valid), LW'(0));
        check_eq("rst_wr_data",  bus.wr_data,       LW'(0));
        @(negedge clk);
        rst = 1'b1;

        // num_samples = 0: done in cycle 1, nothing written
        run(0, 5, 0, 0, 0, 0, 1, 0, 0, 0, 12);
        check_eq("ns0_done_cyc", LW'(done_cyc),      LW'(1));
        check_eq("ns0_nwr",      LW'(wr_cyc.size()), LW'(0));
        check_eq("ns0_ro_en",    LW'(en_hist[1]),    LW'(0));

        // collect_cycles = 0 behaves as 1
        run(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 25);
        check_eq("c0_done_clr", LW'(done_hist[1]),   LW'(0));
        check_eq("c0_nwr",      LW'(wr_cyc.size()),  LW'(1));
        check_eq("c0_wr_cyc",   LW'(wr_at(0)),       LW'(17));
        check_eq("c0_wr_data",  dat_at(0),           pack2(1, 1));
        check_eq("c0_done_cyc", LW'(done_cyc),       LW'(18));

        // one line, C=4, edge every cycle
        run(1, 4, 0, 0, 0, 0, 1, 0, 0, 0, 80);
        check_eq("t1_nwr",      LW'(wr_cyc.size()), LW'(1));
        check_eq("t1_wr_cyc",   LW'(wr_at(0)),      LW'(65));
        check_eq("t1_wr_data",  dat_at(0),          pack2(4, 4));
        check_eq("t1_done_cyc", LW'(done_cyc),      LW'(66));
        check_eq("t1_en_64",    LW'(en_hist[64]),   LW'(1));
        check_eq("t1_en_65",    LW'(en_hist[65]),   LW'(0));
        check_eq("t1_val_64",   LW'(val_hist[64]),  LW'(0));

        // two lines, C=3, edge on odd cycles
        run(2, 3, 0, 0, 0, 0, 2, 0, 0, 0, 110);
        check_eq("t2_nwr",      LW'(wr_cyc.size()), LW'(2));
        check_eq("t2_wr0_cyc",  LW'(wr_at(0)),      LW'(49));
        check_eq("t2_wr1_cyc",  LW'(wr_at(1)),      LW'(98));
        check_eq("t2_wr0_data", dat_at(0),          pack2(2, 1));
        check_eq("t2_wr1_data", dat_at(1),          pack2(1, 2));
        check_eq("t2_done_cyc", LW'(done_cyc),      LW'(99));
        check_eq("t2_en_1",     LW'(en_hist[1]),    LW'(1));
        check_eq("t2_en_48",    LW'(en_hist[48]),   LW'(1));
        check_eq("t2_en_49",    LW'(en_hist[49]),   LW'(0));
        check_eq("t2_en_50",    LW'(en_hist[50]),   LW'(1));
        check_eq("t2_en_98",    LW'(en_hist[98]),   LW'(0));
        check_eq("t2_en_99",    LW'(en_hist[99]),   LW'(0));

        // backpressure: wr_full high for 10 cycles from entry to WRITE (cycle 33)
        run(1, 2, 0, 0, 0, 0, 1, 33, 10, 0, 55);
        check_eq("t3_nwr",      LW'(wr_cyc.size()), LW'(1));
        check_eq("t3_wr_cyc",   LW'(wr_at(0)),      LW'(43));
        check_eq("t3_val_33",   LW'(val_hist[33]),  LW'(0));
        check_eq("t3_val_42",   LW'(val_hist[42]),  LW'(0));
        check_eq("t3_data_33",  data_hist[33],      pack2(2, 2));
        check_eq("t3_wr_data",  dat_at(0),          pack2(2, 2));
        check_eq("t3_en_38",    LW'(en_hist[38]),   LW'(0));
        check_eq("t3_en_43",    LW'(en_hist[43]),   LW'(0));
        check_eq("t3_done_cyc", LW'(done_cyc),      LW'(44));

        // go in COLLECT and WRITE, inputs changed mid-run: ignored
        run(2, 1, 10, 5, 10, 17, 1, 0, 0, 0, 50);
        check_eq("t5_nwr",      LW'(wr_cyc.size()), LW'(2));
        check_eq("t5_wr0_cyc",  LW'(wr_at(0)),      LW'(17));
        check_eq("t5_wr1_cyc",  LW'(wr_at(1)),      LW'(34));
        check_eq("t5_wr1_data", dat_at(1),          pack2(1, 1));
        check_eq("t5_done_cyc", LW'(done_cyc),      LW'(35));

        // reset mid-COLLECT, then a clean run
        run(1, 2, 0, 0, 0, 0, 1, 0, 0, 10, 40);
        check_eq("t6_en_9",     LW'(en_hist[9]),    LW'(1));
        check_eq("t6_en_10",    LW'(en_hist[10]),   LW'(0));
        check_eq("t6_data_10",  data_hist[10],      LW'(0));
        check_eq("t6_done_10",  LW'(done_hist[10]), LW'(0));
        check_eq("t6_nwr_abrt", LW'(wr_cyc.size()), LW'(0));
        @(negedge clk);
        rst = 1'b1;
        run(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 25);
        check_eq("t6_nwr",      LW'(wr_cyc.size()), LW'(1));
        check_eq("t6_wr_cyc",   LW'(wr_at(0)),      LW'(17));
        check_eq("t6_wr_data",  dat_at(0),          pack2(1, 1));
        check_eq("t6_done_cyc", LW'(done_cyc),      LW'(18));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
